mprj_uart_tx: RTL

User-project UART transmitter that drives the management SoC's serial receive pin (mprj_io[5]) so the user area can send bytes to firmware, the reverse of the testbench UART monitor on mprj_io[6]. It accepts bytes over a valid/ready write port, buffers them in a small FIFO, and serialises each as an 8N1 frame, LSB first, at a runtime-programmable bit period. It sits in the user project area, clocked by the wishbone/user clock, with ser_tx routed to the IO pad via the user project's io_out/io_oeb.

---
 rtl/mprj_uart_defs.sv | 30 +++
 rtl/mprj_uart_tx_if.sv | 21 ++
 rtl/mprj_uart_fifo.sv | 62 ++++++
 rtl/mprj_uart_tx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mprj_uart_defs.sv
// Shared definitions for the user-project UART transmitter: FSM state
// encoding, frame shape constants and the idle line level.
package mprj_uart_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned DATA_BITS    = 32'd8;
   localparam int unsigned STOP_BITS    = 32'd1;
   localparam logic        IDLE_LEVEL   = 1'b1;
   localparam logic [2:0]  LAST_BIT_IDX = 3'(DATA_BITS - 32'd1);

   // Line level the transmitter presents while in a given state.
   function automatic logic line_level(input uart_state_e state, input logic data_bit);
      logic lvl;
      case (state)
         ST_IDLE:  lvl = IDLE_LEVEL;
         ST_START: lvl = ~IDLE_LEVEL;
         ST_DATA:  lvl = data_bit;
         ST_STOP:  lvl = IDLE_LEVEL;
         default:  lvl = IDLE_LEVEL;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/mprj_uart_tx_if.sv
// Byte write port of the UART transmitter: valid/ready handshake.
// The producer uses the master view, the transmitter the slave view.
interface mprj_uart_tx_if;

   logic [7:0] wdata;
   logic       wvalid;
   logic       wready;

   modport master (
      output wdata,
      output wvalid,
      input  wready
   );

   modport slave (
      input  wdata,
      input  wvalid,
      output wready
   );

endinterface

// File: rtl/mprj_uart_fifo.sv
// Single-clock byte FIFO. Pointers carry one extra wrap bit so that full and
// empty are told apart without a separate counter; the level is the pointer
// difference. Pushes while full and pops while empty are ignored.
module mprj_uart_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     resetb,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign push_ok_s = push && !full_s;
   assign pop_ok_s  = pop && !empty_s;

   assign full  = full_s;
   assign empty = empty_s;
   assign level = wr_ptr_r - rd_ptr_r;
   assign rdata = mem_r[rd_ptr_r[AW-1:0]];

   // Storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

   // Write and read pointers; a reset empties the FIFO.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
         end
      end
   end

endmodule

// File: rtl/mprj_uart_tx.sv
// User-project UART transmitter feeding the management SoC serial input.
// Bytes are buffered in a small FIFO and sent as 8N1 frames, LSB first, with
// a bit period of (clk_div + 1) clocks latched at the start of every frame.
// ser_tx and busy are registered from the current state, so the line follows
// the FSM by one clock.
module mprj_uart_tx
   import mprj_uart_defs::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                         clock,
   input  logic                         resetb,
   input  logic                         enable,
   input  logic [DIV_W-1:0]             clk_div,
   mprj_uart_tx_if.slave                wr,
   output logic                         ser_tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

   uart_state_e       state_r;
   uart_state_e       state_next_s;
   logic [DIV_W-1:0]  cnt_r;
   logic [DIV_W-1:0]  cnt_next_s;
   logic [DIV_W-1:0]  period_r;
   logic [DIV_W-1:0]  period_next_s;
   logic [2:0]        idx_r;
   logic [2:0]        idx_next_s;
   logic [7:0]        shift_r;
   logic [7:0]        shift_next_s;
   logic              ser_tx_r;
   logic              busy_r;
   logic              line_next_s;
   logic              busy_next_s;
   logic              pop_s;
   logic [7:0]        fifo_rdata_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              bit_end_s;

   mprj_uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clock  (clock),
      .resetb (resetb),
      .push   (wr.wvalid),
      .wdata  (wr.wdata),
      .pop    (pop_s),
      .rdata  (fifo_rdata_s),
      .full   (fifo_full_s),
      .empty  (fifo_empty_s),
      .level  (fifo_level)
   );

   assign wr.wready = ~fifo_full_s;
   assign bit_end_s = (cnt_r == {DIV_W{1'b0}});
   assign ser_tx    = ser_tx_r;
   assign busy      = busy_r;

   // Next-state, bit timing, shift register and FIFO pop decisions.
   always_comb begin
      state_next_s  = state_r;
      cnt_next_s    = cnt_r;
      period_next_s = period_r;
      idx_next_s    = idx_r;
      shift_next_s  = shift_r;
      pop_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable && !fifo_empty_s) begin
               pop_s         = 1'b1;
               shift_next_s  = fifo_rdata_s;
               period_next_s = clk_div;
               cnt_next_s    = clk_div;
               idx_next_s    = 3'd0;
               state_next_s  = ST_START;
            end else begin
               state_next_s  = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               cnt_next_s   = period_r;
               idx_next_s   = 3'd0;
               state_next_s = ST_DATA;
            end else begin
               cnt_next_s   = cnt_r - DIV_W'(1'b1);
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               cnt_next_s   = period_r;
               shift_next_s = {1'b0, shift_r[7:1]};
               if (idx_r == LAST_BIT_IDX) begin
                  state_next_s = ST_STOP;
               end else begin
                  idx_next_s   = idx_r + 3'd1;
               end
            end else begin
               cnt_next_s   = cnt_r - DIV_W'(1'b1);
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               state_next_s = ST_IDLE;
            end else begin
               cnt_next_s   = cnt_r - DIV_W'(1'b1);
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Line level and busy flag for the current state, registered below.
   always_comb begin
      line_next_s = line_level(state_r, shift_r[0]);
      busy_next_s = (state_r != ST_IDLE);
   end

   // FSM state register; reset abandons any frame in flight.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Bit timing, data path and registered outputs; reset forces the line idle.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         cnt_r    <= {DIV_W{1'b0}};
         period_r <= {DIV_W{1'b0}};
         idx_r    <= 3'd0;
         shift_r  <= 8'h00;
         ser_tx_r <= IDLE_LEVEL;
         busy_r   <= 1'b0;
      end else begin
         cnt_r    <= cnt_next_s;
         period_r <= period_next_s;
         idx_r    <= idx_next_s;
         shift_r  <= shift_next_s;
         ser_tx_r <= line_next_s;
         busy_r   <= busy_next_s;
      end
   end

endmodule
